// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush > stall > load > bubble.
// Latency: 1 cycle from load_i to valid_o.
// Backpressure: stall_i freezes every field; flush_i overrides stall_i.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   flush_i/stall_i     - hazard controls
//   load_i/instr_i/pc_i - new instruction to capture
//   valid_o/instr_o/pc_o/pc_plus4_o - registered IF/ID contents
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);
  import fetch_pkg::*;

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else if (flush_i) begin
      // PC fields are left alone on a flush; only the payload is squashed.
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (stall_i) begin
      valid_q <= valid_q;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + PC_STEP;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request FSM, IF/ID register.
// Latency: request cycle n, response n+1, IF/ID valid n+2 (1 instr / 2 cycles).
// Backpressure: waits on imem_req_ready_in; stall_in parks a response in a hold buffer.
// Ports:
//   clk, rst_n                        - clock, async active-low reset
//   stall_in, flush_in                - hazard unit controls
//   redirect_valid_in/redirect_pc_in  - EX branch/jump target
//   imem_req_*                        - request channel (valid/ready)
//   imem_rsp_*                        - response channel (valid only)
//   ID_*                              - IF/ID register outputs
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_valid_out,
  output logic [31:0] imem_req_addr_out,
  input  logic        imem_req_ready_in,
  input  logic        imem_rsp_valid_in,
  input  logic [31:0] imem_rsp_data_in,
  output logic        ID_valid_out,
  output logic [31:0] ID_instr_out,
  output logic [31:0] ID_pc_out,
  output logic [31:0] ID_pc_plus4_out
);
  import fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  hold_q, hold_d;
  logic         deliver;
  logic [31:0]  deliver_instr;
  logic [31:0]  redir_pc;
  logic         unused_redir_lsbs;

  assign redir_pc          = {redirect_pc_in[31:2], 2'b00};
  assign unused_redir_lsbs = ^redirect_pc_in[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    hold_d        = hold_q;
    deliver       = 1'b0;
    deliver_instr = imem_rsp_data_in;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // The address may move under an unaccepted request; a redirect racing
        // the handshake leaves a stale response in flight, marked by drop.
        if (redirect_valid_in) pc_d = redir_pc;
        if (imem_req_ready_in) begin
          state_d = S_WAIT;
          if (redirect_valid_in) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_in) begin
          state_d = S_REQ;
          if (drop_q) begin
            drop_d = 1'b0;
            if (redirect_valid_in) pc_d = redir_pc;
          end else if (redirect_valid_in) begin
            pc_d = redir_pc;
          end else if (!stall_in) begin
            deliver = 1'b1;
            pc_d    = pc_q + PC_STEP;
          end else begin
            hold_d  = imem_rsp_data_in;
            state_d = S_HOLD;
          end
        end else if (redirect_valid_in) begin
          drop_d = 1'b1;
          pc_d   = redir_pc;
        end
      end
      S_HOLD: begin
        if (redirect_valid_in) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else if (!stall_in) begin
          deliver       = 1'b1;
          deliver_instr = hold_q;
          pc_d          = pc_q + PC_STEP;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req_valid_out = (state_q == S_REQ);
  assign imem_req_addr_out  = pc_q;

  // A delivery under flush is squashed in IF/ID but pc has still advanced.
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_in),
    .stall_i    (stall_in),
    .load_i     (deliver),
    .instr_i    (deliver_instr),
    .pc_i       (pc_q),
    .valid_o    (ID_valid_out),
    .instr_o    (ID_instr_out),
    .pc_o       (ID_pc_out),
    .pc_plus4_o (ID_pc_plus4_out)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, redir_v = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        req_valid, req_ready = 1'b1;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc4;

  logic        zero = 1'b0;
  logic [31:0] zero32 = '0;
  logic        one = 1'b1;
  logic        req_valid2;
  logic [31:0] req_addr2;
  logic        rsp_valid2 = 1'b0;
  logic [31:0] rsp_data2 = '0;
  logic        id_valid2;
  logic [31:0] id_instr2, id_pc2, id_pc42;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall), .flush_in(flush),
    .redirect_valid_in(redir_v), .redirect_pc_in(redir_pc),
    .imem_req_valid_out(req_valid), .imem_req_addr_out(req_addr),
    .imem_req_ready_in(req_ready), .imem_rsp_valid_in(rsp_valid),
    .imem_rsp_data_in(rsp_data), .ID_valid_out(id_valid),
    .ID_instr_out(id_instr), .ID_pc_out(id_pc), .ID_pc_plus4_out(id_pc4)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall_in(zero), .flush_in(zero),
    .redirect_valid_in(zero), .redirect_pc_in(zero32),
    .imem_req_valid_out(req_valid2), .imem_req_addr_out(req_addr2),
    .imem_req_ready_in(one), .imem_rsp_valid_in(rsp_valid2),
    .imem_rsp_data_in(rsp_data2), .ID_valid_out(id_valid2),
    .ID_instr_out(id_instr2), .ID_pc_out(id_pc2), .ID_pc_plus4_out(id_pc42)
  );

  // Memory model for dut: responds mem_lat cycles after the handshake with addr^K.
  logic        m_hs;
  logic [31:0] m_a, m_pend;
  int          m_cnt = 0;
  always @(posedge clk) begin
    m_hs = req_valid && req_ready;
    m_a  = req_addr;
    #1;
    rsp_valid = 1'b0;
    if (!rst_n) m_cnt = 0;
    else begin
      if (m_hs) begin m_pend = m_a; m_cnt = mem_lat; end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin rsp_valid = 1'b1; rsp_data = m_pend ^ K; end
      end
    end
  end

  // Memory model for dut2: always ready, 1-cycle response.
  logic        m2_hs;
  logic [31:0] m2_a;
  always @(posedge clk) begin
    m2_hs = req_valid2;
    m2_a  = req_addr2;
    #1;
    rsp_valid2 = rst_n && m2_hs;
    rsp_data2  = m2_a ^ K;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redir_v = 1'b0;
    redir_pc = '0; req_ready = 1'b1; mem_lat = 1;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %0b exp 0", req_valid); end
    checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr got %h exp 00000000", req_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %0b exp 0", id_valid); end
    checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL rst_id_instr got %h exp 00000013", id_instr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc got %h exp 00000000", id_pc); end
    checks++; if (id_pc4 !== 32'h4) begin errors++; $display("FAIL rst_id_pc4 got %h exp 00000004", id_pc4); end
    checks++; if (req_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_req_addr2 got %h exp fffffffc", req_addr2); end
  endtask

  task automatic test_basic();
    do_reset();
    tick();
    checks++; if ({req_valid, req_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL basic_req0 got %0b/%h exp 1/00000000", req_valid, req_addr); end
    tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_novalid got %0b exp 0", req_valid); end
    tick();
    checks++; if ({id_valid, id_pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL basic_id0 got %0b/%h exp 1/00000000", id_valid, id_pc); end
    checks++; if (id_instr !== 32'hA5A5_0000) begin errors++; $display("FAIL basic_instr0 got %h exp a5a50000", id_instr); end
    checks++; if ({req_valid, req_addr} !== {1'b1, 32'h4}) begin errors++; $display("FAIL basic_req4 got %0b/%h exp 1/00000004", req_valid, req_addr); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL basic_bubble got %0b exp 0", id_valid); end
    tick();
    checks++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h4, 32'hA5A5_0004}) begin errors++; $display("FAIL basic_id4 got %0b/%h/%h exp 1/00000004/a5a50004", id_valid, id_pc, id_instr); end
    checks++; if (id_pc4 !== 32'h8) begin errors++; $display("FAIL basic_pc4 got %h exp 00000008", id_pc4); end
    checks++; if ({req_valid, req_addr} !== {1'b1, 32'h8}) begin errors++; $display("FAIL basic_req8 got %0b/%h exp 1/00000008", req_valid, req_addr); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(3);
    stall = 1'b1;                     // REQ for addr 4 still handshakes
    tick();
    checks++; if ({id_valid, id_pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL stall_hold1 got %0b/%h exp 1/00000000", id_valid, id_pc); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_rsp_present got %0b exp 1", rsp_valid); end
    for (int i = 0; i < 2; i++) begin
      tick();                         // response parked in hold buffer
      checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL stall_noreq%0d got %0b exp 0", i, req_valid); end
      checks++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h0, 32'hA5A5_0000}) begin errors++; $display("FAIL stall_idhold%0d got %0b/%h/%h exp 1/00000000/a5a50000", i, id_valid, id_pc, id_instr); end
    end
    stall = 1'b0;
    tick();
    checks++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h4, 32'hA5A5_0004}) begin errors++; $display("FAIL stall_release got %0b/%h/%h exp 1/00000004/a5a50004", id_valid, id_pc, id_instr); end
    checks++; if ({req_valid, req_addr} !== {1'b1, 32'h8}) begin errors++; $display("FAIL stall_nextreq got %0b/%h exp 1/00000008", req_valid, req_addr); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stall_once got %0b exp 0", id_valid); end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_lat = 3;
    tick(2);                          // in WAIT for addr 0, response 3 cycles out
    redir_v = 1'b1; redir_pc = 32'h0000_0101;
    tick();
    redir_v = 1'b0;
    checks++; if ({req_valid, req_addr} !== {1'b0, 32'h100}) begin errors++; $display("FAIL redir_wait got %0b/%h exp 0/00000100", req_valid, req_addr); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_noid_a got %0b exp 0", id_valid); end
    tick();
    mem_lat = 1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_dropped got %0b exp 0", id_valid); end
    checks++; if ({req_valid, req_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL redir_req got %0b/%h exp 1/00000100", req_valid, req_addr); end
    tick(2);
    checks++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h100, 32'hA5A5_0100}) begin errors++; $display("FAIL redir_id got %0b/%h/%h exp 1/00000100/a5a50100", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    tick(3);
    flush = 1'b1; stall = 1'b1;
    tick();
    checks++; if ({id_valid, id_instr} !== {1'b0, 32'h13}) begin errors++; $display("FAIL flush_over_stall got %0b/%h exp 0/00000013", id_valid, id_instr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL flush_pc_kept got %h exp 00000000", id_pc); end
    stall = 1'b0;                     // response for addr 4 delivered under flush
    tick();
    flush = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_deliver_squash got %0b exp 0", id_valid); end
    checks++; if ({req_valid, req_addr} !== {1'b1, 32'h8}) begin errors++; $display("FAIL flush_pc_adv got %0b/%h exp 1/00000008", req_valid, req_addr); end
  endtask

  task automatic test_ready_low();
    do_reset();
    req_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({req_valid, req_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL ready_low%0d got %0b/%h exp 1/00000000", i, req_valid, req_addr); end
    end
    req_ready = 1'b1;
    tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL ready_hs got %0b exp 0", req_valid); end
    tick();
    checks++; if ({id_valid, id_pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL ready_id got %0b/%h exp 1/00000000", id_valid, id_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    checks++; if ({req_valid2, req_addr2} !== {1'b1, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_req0 got %0b/%h exp 1/fffffffc", req_valid2, req_addr2); end
    tick(2);
    checks++; if ({id_valid2, id_pc2} !== {1'b1, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_id got %0b/%h exp 1/fffffffc", id_valid2, id_pc2); end
    checks++; if (id_instr2 !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_instr got %h exp 5a5afffc", id_instr2); end
    checks++; if (id_pc42 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 00000000", id_pc42); end
    checks++; if ({req_valid2, req_addr2} !== {1'b1, 32'h0}) begin errors++; $display("FAIL wrap_req1 got %0b/%h exp 1/00000000", req_valid2, req_addr2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_flush_stall();
    test_ready_low();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
